// File: rtl/up_lcd_pkg.sv
// Shared constants and types for the up_lcd SPI transmit controller.
package up_lcd_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_GPO    = 2;
  localparam int unsigned ADDR_GPI    = 3;
  localparam int unsigned ADDR_TXDATA = 9;
  localparam int unsigned ADDR_CLKDIV = 10;

  localparam int unsigned CTRL_START     = 16;
  localparam int unsigned CTRL_LEN_LSB   = 8;
  localparam int unsigned CTRL_LEN_W     = 8;
  localparam int unsigned CTRL_CSIDX_LSB = 4;
  localparam int unsigned CTRL_CSIDX_W   = 4;
  localparam int unsigned CTRL_MSBF      = 3;
  localparam int unsigned CTRL_CSHOLD    = 2;

  localparam int unsigned LEN_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    TAIL
  } shift_state_e;

  // Bit counts above the shift register width saturate at 32.
  function automatic logic [5:0] clamp_len(input logic [7:0] len);
    return (len > 8'(LEN_MAX)) ? 6'(LEN_MAX) : 6'(len);
  endfunction

endpackage

// File: rtl/up_lcd_spi_shift.sv
// SPI mode-0 shift engine: half-period divider, bit counter and shift register.
module up_lcd_spi_shift
  import up_lcd_pkg::*;
(
  input  logic        clk_r,
  input  logic        rst_r,
  input  logic        start_i,
  input  logic [5:0]  len_i,
  input  logic        msbf_i,
  input  logic [31:0] txdata_i,
  input  logic [7:0]  div_i,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        dat_o,
  output logic        last_c
);

  shift_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bits_q, bits_d;
  logic [31:0] sr_q, sr_d;
  logic        msbf_q, msbf_d;
  logic        sclk_q, sclk_d;
  logic        dat_q, dat_d;
  logic        busy_q, busy_d;
  logic [31:0] sr_load;
  logic [31:0] sr_next;

  // MSB-first aligns bit LEN-1 to bit 31 so both orders shift out of a fixed end.
  assign sr_load = msbf_i ? (txdata_i << (6'(LEN_MAX) - len_i)) : txdata_i;
  assign sr_next = msbf_q ? {sr_q[30:0], 1'b0} : {1'b0, sr_q[31:1]};

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      msbf_q  <= 1'b0;
      sclk_q  <= 1'b0;
      dat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      sr_q    <= sr_d;
      msbf_q  <= msbf_d;
      sclk_q  <= sclk_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bits_d  = bits_q;
    sr_d    = sr_q;
    msbf_d  = msbf_q;
    sclk_d  = sclk_q;
    dat_d   = dat_q;
    last_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = sr_load;
          dat_d   = msbf_i ? sr_load[31] : sr_load[0];
          bits_d  = len_i;
          msbf_d  = msbf_i;
          div_d   = div_i;
          cnt_d   = div_i;
          sclk_d  = 1'b0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == 8'd0) begin
          sclk_d  = 1'b1;
          cnt_d   = div_q;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == 8'd0) begin
          sclk_d = 1'b0;
          cnt_d  = div_q;
          if (bits_q == 6'd1) begin
            state_d = TAIL;
          end else begin
            sr_d    = sr_next;
            dat_d   = msbf_q ? sr_next[31] : sr_next[0];
            bits_d  = bits_q - 6'd1;
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      TAIL: begin
        if (cnt_q == 8'd0) begin
          last_c  = 1'b1;
          dat_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign busy_o = busy_q;
  assign sclk_o = sclk_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/up_lcd_ctrl.sv
// Register-mapped SPI transmit controller for serial LCD panels.
// Optional UP_LCD_GPI_SYNC_EN adds a 2-flop synchronizer on spi_gpi_i.
module up_lcd_ctrl
  import up_lcd_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned CS_CNT        = 2,
  parameter int unsigned GPI_CNT       = 1,
  parameter int unsigned GPO_CNT       = 1
) (
  input  logic                     clk_r,
  input  logic                     rst_r,
  input  logic                     up_wreq,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  input  logic                     up_rreq,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [31:0]              up_rdata,
  output logic                     up_rack,
  output logic                     spi_clk_o,
  output logic                     spi_dat_o,
  output logic [CS_CNT-1:0]        spi_cs_o,
  output logic [GPO_CNT-1:0]       spi_gpo_o,
  input  logic [GPI_CNT-1:0]       spi_gpi_i
);

  logic [7:0]         len_q, len_d;
  logic [3:0]         csidx_q, csidx_d;
  logic               msbf_q, msbf_d;
  logic               cshold_q, cshold_d;
  logic [1:0]         spare_q, spare_d;
  logic [31:0]        txdata_q, txdata_d;
  logic [7:0]         clkdiv_q, clkdiv_d;
  logic [GPO_CNT-1:0] gpo_q, gpo_d;
  logic               cs_act_q, cs_act_d;
  logic [3:0]         cs_sel_q, cs_sel_d;
  logic [CS_CNT-1:0]  cs_q, cs_d;
  logic               wack_q, wack_d;
  logic               rack_q, rack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [GPI_CNT-1:0] gpi_c;

  logic       eng_busy;
  logic       eng_last_c;
  logic       ctrl_wr_c;
  logic       start_c;
  logic [5:0] wr_len_c;

  assign wr_len_c  = clamp_len(up_wdata[CTRL_LEN_LSB +: CTRL_LEN_W]);
  assign ctrl_wr_c = up_wreq && (up_waddr == ADDRESS_WIDTH'(ADDR_CTRL)) && !eng_busy;
  assign start_c   = ctrl_wr_c && up_wdata[CTRL_START] && (wr_len_c != 6'd0);

`ifdef UP_LCD_GPI_SYNC_EN
  logic [GPI_CNT-1:0] gpi_s1_q, gpi_s2_q;
  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      gpi_s1_q <= '0;
      gpi_s2_q <= '0;
    end else begin
      gpi_s1_q <= spi_gpi_i;
      gpi_s2_q <= gpi_s1_q;
    end
  end
  assign gpi_c = gpi_s2_q;
`else
  assign gpi_c = spi_gpi_i;
`endif

  up_lcd_spi_shift u_shift (
    .clk_r    (clk_r),
    .rst_r    (rst_r),
    .start_i  (start_c),
    .len_i    (wr_len_c),
    .msbf_i   (up_wdata[CTRL_MSBF]),
    .txdata_i (txdata_q),
    .div_i    (clkdiv_q),
    .busy_o   (eng_busy),
    .sclk_o   (spi_clk_o),
    .dat_o    (spi_dat_o),
    .last_c   (eng_last_c)
  );

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      len_q    <= '0;
      csidx_q  <= '0;
      msbf_q   <= 1'b0;
      cshold_q <= 1'b0;
      spare_q  <= '0;
      txdata_q <= '0;
      clkdiv_q <= '0;
      gpo_q    <= '0;
      cs_act_q <= 1'b0;
      cs_sel_q <= '0;
      cs_q     <= '1;
      wack_q   <= 1'b0;
      rack_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      len_q    <= len_d;
      csidx_q  <= csidx_d;
      msbf_q   <= msbf_d;
      cshold_q <= cshold_d;
      spare_q  <= spare_d;
      txdata_q <= txdata_d;
      clkdiv_q <= clkdiv_d;
      gpo_q    <= gpo_d;
      cs_act_q <= cs_act_d;
      cs_sel_q <= cs_sel_d;
      cs_q     <= cs_d;
      wack_q   <= wack_d;
      rack_q   <= rack_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    len_d    = len_q;
    csidx_d  = csidx_q;
    msbf_d   = msbf_q;
    cshold_d = cshold_q;
    spare_d  = spare_q;
    txdata_d = txdata_q;
    clkdiv_d = clkdiv_q;
    gpo_d    = gpo_q;
    cs_act_d = cs_act_q;
    cs_sel_d = cs_sel_q;
    wack_d   = up_wreq;
    rack_d   = up_rreq;
    rdata_d  = '0;

    // Configuration registers freeze while a transfer runs; GPO never does.
    if (up_wreq) begin
      case (up_waddr)
        ADDRESS_WIDTH'(ADDR_CTRL): if (!eng_busy) begin
          len_d    = up_wdata[CTRL_LEN_LSB +: CTRL_LEN_W];
          csidx_d  = up_wdata[CTRL_CSIDX_LSB +: CTRL_CSIDX_W];
          msbf_d   = up_wdata[CTRL_MSBF];
          cshold_d = up_wdata[CTRL_CSHOLD];
          spare_d  = up_wdata[1:0];
        end
        ADDRESS_WIDTH'(ADDR_TXDATA): if (!eng_busy) txdata_d = up_wdata;
        ADDRESS_WIDTH'(ADDR_CLKDIV): if (!eng_busy) clkdiv_d = up_wdata[7:0];
        ADDRESS_WIDTH'(ADDR_GPO):    gpo_d = up_wdata[GPO_CNT-1:0];
        default: ;
      endcase
    end

    // CS tracks the active transfer, or lingers after one that asked to hold it.
    if (start_c) begin
      cs_act_d = 1'b1;
      cs_sel_d = up_wdata[CTRL_CSIDX_LSB +: CTRL_CSIDX_W];
    end else if (eng_last_c && !cshold_q) begin
      cs_act_d = 1'b0;
    end else if (ctrl_wr_c && !up_wdata[CTRL_CSHOLD]) begin
      cs_act_d = 1'b0;
    end

    for (int unsigned i = 0; i < CS_CNT; i++) begin
      cs_d[i] = !(cs_act_d && (cs_sel_d == 4'(i)));
    end

    if (up_rreq) begin
      case (up_raddr)
        ADDRESS_WIDTH'(ADDR_CTRL):   rdata_d = {16'd0, len_q, csidx_q, msbf_q, cshold_q, spare_q};
        ADDRESS_WIDTH'(ADDR_STATUS): rdata_d = {31'd0, eng_busy};
        ADDRESS_WIDTH'(ADDR_GPO):    rdata_d = 32'(gpo_q);
        ADDRESS_WIDTH'(ADDR_GPI):    rdata_d = 32'(gpi_c);
        ADDRESS_WIDTH'(ADDR_TXDATA): rdata_d = txdata_q;
        ADDRESS_WIDTH'(ADDR_CLKDIV): rdata_d = {24'd0, clkdiv_q};
        default:                     rdata_d = '0;
      endcase
    end
  end

  assign up_wack   = wack_q;
  assign up_rack   = rack_q;
  assign up_rdata  = rdata_q;
  assign spi_cs_o  = cs_q;
  assign spi_gpo_o = gpo_q;

endmodule

// File: tb/tb_up_lcd_ctrl.sv
// Directed self-checking bench for up_lcd_ctrl.
module tb_up_lcd_ctrl;

  logic        clk_r;
  logic        rst_r;
  logic        up_wreq;
  logic [11:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [11:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic        spi_clk_o;
  logic        spi_dat_o;
  logic [1:0]  spi_cs_o;
  logic [0:0]  spi_gpo_o;
  logic [0:0]  spi_gpi_i;

  int n_checks;
  int n_errors;

  up_lcd_ctrl #(
    .ADDRESS_WIDTH (12),
    .CS_CNT        (2),
    .GPI_CNT       (1),
    .GPO_CNT       (1)
  ) dut (
    .clk_r     (clk_r),
    .rst_r     (rst_r),
    .up_wreq   (up_wreq),
    .up_waddr  (up_waddr),
    .up_wdata  (up_wdata),
    .up_wack   (up_wack),
    .up_rreq   (up_rreq),
    .up_raddr  (up_raddr),
    .up_rdata  (up_rdata),
    .up_rack   (up_rack),
    .spi_clk_o (spi_clk_o),
    .spi_dat_o (spi_dat_o),
    .spi_cs_o  (spi_cs_o),
    .spi_gpo_o (spi_gpo_o),
    .spi_gpi_i (spi_gpi_i)
  );

  initial clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the write.
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    up_wreq  = 1'b1;
    up_waddr = a;
    up_wdata = d;
    @(posedge clk_r); #1;
    up_wreq = 1'b0;
    check("wack", 32'(up_wack), 32'd1);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
    up_rreq  = 1'b1;
    up_raddr = a;
    @(posedge clk_r); #1;
    up_rreq = 1'b0;
    check("rack", 32'(up_rack), 32'd1);
    d = up_rdata;
  endtask

  // Counts cycles with the selected CS low and collects data at each SCLK rise.
  task automatic measure(input int idx, output int n, output int rises, output logic [31:0] bits);
    logic prev;
    n     = 0;
    rises = 0;
    bits  = '0;
    prev  = 1'b0;
    while (spi_cs_o[idx] == 1'b0 && n < 200) begin
      if (spi_clk_o && !prev) begin
        rises++;
        bits = {bits[30:0], spi_dat_o};
      end
      prev = spi_clk_o;
      n++;
      @(posedge clk_r); #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] bits;
    int n;
    int rises;
    n_checks  = 0;
    n_errors  = 0;
    rst_r     = 1'b1;
    up_wreq   = 1'b0;
    up_waddr  = '0;
    up_wdata  = '0;
    up_rreq   = 1'b0;
    up_raddr  = '0;
    spi_gpi_i = 1'b0;

    #2;
    check("rst_cs",    32'(spi_cs_o),  32'h3);
    check("rst_sclk",  32'(spi_clk_o), 32'h0);
    check("rst_dat",   32'(spi_dat_o), 32'h0);
    check("rst_gpo",   32'(spi_gpo_o), 32'h0);
    check("rst_wack",  32'(up_wack),   32'h0);
    check("rst_rack",  32'(up_rack),   32'h0);
    check("rst_rdata", up_rdata,       32'h0);
    repeat (3) @(posedge clk_r);
    #1 rst_r = 1'b0;
    @(posedge clk_r); #1;

    bus_rd(12'h3, rd); check("gpi0", rd, 32'h0);
    spi_gpi_i = 1'b1;
    bus_wr(12'hA, 32'h1);
    bus_wr(12'h9, 32'h34);
    bus_rd(12'h1, rd); check("status_idle", rd, 32'h0);
    bus_rd(12'hA, rd); check("clkdiv_rd", rd, 32'h1);
    bus_rd(12'h9, rd); check("txdata_rd", rd, 32'h34);
    bus_rd(12'h5, rd); check("unmapped_rd", rd, 32'h0);

    // MSB first, 8 bits, DIV=1
    bus_wr(12'h0, 32'h10809);
    check("msb_cs_start", 32'(spi_cs_o), 32'h2);
    measure(0, n, rises, bits);
    check("msb_cs_cycles", 32'(n), 32'd34);
    check("msb_rises", 32'(rises), 32'd8);
    check("msb_bits", bits, 32'h34);
    check("msb_dat_end", 32'(spi_dat_o), 32'h0);
    bus_rd(12'h1, rd); check("msb_status_end", rd, 32'h0);

    // LSB first
    bus_wr(12'h0, 32'h10802);
    measure(0, n, rises, bits);
    check("lsb_cs_cycles", 32'(n), 32'd34);
    check("lsb_rises", 32'(rises), 32'd8);
    check("lsb_bits", bits, 32'h2C);

    // START while busy is ignored; GPO and GPI still serviced
    bus_wr(12'h0, 32'h10809);
    bus_wr(12'h0, 32'h10802);
    bus_rd(12'h1, rd); check("busy_status", rd, 32'h1);
    bus_wr(12'h2, 32'h1);
    check("gpo_mid", 32'(spi_gpo_o), 32'h1);
    bus_rd(12'h3, rd); check("gpi1", rd, 32'h1);
    measure(0, n, rises, bits);
    check("busy_cs_cycles", 32'(n), 32'd30);
    check("busy_rises", 32'(rises), 32'd7);
    check("busy_bits", bits, 32'h34);
    bus_rd(12'h0, rd); check("busy_ctrl_kept", rd, 32'h809);
    bus_rd(12'h1, rd); check("busy_status_end", rd, 32'h0);

    // CSHOLD on CS1, LEN=12, then release
    bus_wr(12'h0, 32'h10C14);
    check("hold_cs_start", 32'(spi_cs_o), 32'h1);
    repeat (50) begin @(posedge clk_r); #1; end
    bus_rd(12'h1, rd); check("hold_status", rd, 32'h0);
    check("hold_cs_after", 32'(spi_cs_o), 32'h1);
    bus_wr(12'h0, 32'h0);
    check("hold_release", 32'(spi_cs_o), 32'h3);
    bus_rd(12'h0, rd); check("ctrl_zero", rd, 32'h0);

    // DIV=0, LEN clamped from 64 to 32
    bus_wr(12'hA, 32'h0);
    bus_wr(12'h9, 32'h80000001);
    bus_wr(12'h0, 32'h14008);
    measure(0, n, rises, bits);
    check("len32_cycles", 32'(n), 32'd65);
    check("len32_rises", 32'(rises), 32'd32);
    check("len32_bits", bits, 32'h80000001);

    // LEN=0: fields stored, nothing starts
    bus_wr(12'h0, 32'h10005);
    check("len0_cs", 32'(spi_cs_o), 32'h3);
    bus_rd(12'h1, rd); check("len0_status", rd, 32'h0);
    bus_rd(12'h0, rd); check("len0_ctrl", rd, 32'h5);

    // CSIDX beyond CS_CNT: clocks run, no CS
    bus_wr(12'h0, 32'h10130);
    check("csidx3_cs", 32'(spi_cs_o), 32'h3);
    bus_rd(12'h1, rd); check("csidx3_busy", rd, 32'h1);
    repeat (4) begin @(posedge clk_r); #1; end
    bus_rd(12'h1, rd); check("csidx3_done", rd, 32'h0);

    // Reset in the middle of a transfer
    bus_wr(12'hA, 32'h1);
    bus_wr(12'h9, 32'h34);
    bus_wr(12'h0, 32'h10809);
    repeat (10) begin @(posedge clk_r); #1; end
    check("pre_rst_sclk", 32'(spi_clk_o), 32'h1);
    check("pre_rst_dat", 32'(spi_dat_o), 32'h1);
    check("pre_rst_cs", 32'(spi_cs_o), 32'h2);
    rst_r = 1'b1;
    #1;
    check("abort_cs", 32'(spi_cs_o), 32'h3);
    check("abort_sclk", 32'(spi_clk_o), 32'h0);
    check("abort_dat", 32'(spi_dat_o), 32'h0);
    check("abort_gpo", 32'(spi_gpo_o), 32'h0);
    @(posedge clk_r); #1;
    rst_r = 1'b0;
    @(posedge clk_r); #1;
    bus_rd(12'hA, rd); check("abort_clkdiv", rd, 32'h0);
    bus_rd(12'h1, rd); check("abort_status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/up_lcd_ctrl.md
# up_lcd_ctrl

Register-mapped SPI transmit controller for serial LCD panels. It sits on the processor register bus (up_* write/read handshake) and drives SPI clock, data, active-low chip selects, and general-purpose outputs. It also samples general-purpose inputs. It is transmit-only: there is no MISO path.

## Interface
- ADDRESS_WIDTH, 12: width of up_waddr/up_raddr.
- CS_CNT, 2: number of chip-select lines (1..16).
- GPI_CNT, 1: number of general-purpose inputs (1..32).
- GPO_CNT, 1: number of general-purpose outputs (1..32).
- clk_r  in  1  clock; all logic is on the rising edge.
- rst_r  in  1  reset, asynchronous, active-high.
- up_wreq  in  1  one-cycle write strobe.
- up_waddr  in  ADDRESS_WIDTH  word address for writes.
- up_wdata  in  32  write data.
- up_wack  out  1  write acknowledge.
- up_rreq  in  1  one-cycle read strobe.
- up_raddr  in  ADDRESS_WIDTH  word address for reads.
- up_rdata  out  32  read data.
- up_rack  out  1  read acknowledge.
- spi_clk_o  out  1  SPI clock, mode 0 (idle low).
- spi_dat_o  out  1  SPI data (MOSI).
- spi_cs_o  out  CS_CNT  chip selects, active low.
- spi_gpo_o  out  GPO_CNT  general-purpose outputs (D/C, backlight, reset).
- spi_gpi_i  in  GPI_CNT  general-purpose inputs.

## Operation
- Register map (R/W unless noted; unmapped reads return 0, unmapped writes are acked and discarded):
  - 0x0 CTRL: [16] START (write-only, self-clearing, reads 0); [15:8] LEN (bit count); [7:4] CSIDX; [3] MSBF (1 = MSB first); [2] CSHOLD; [1:0] spare, stored and read back.
  - 0x1 STATUS (RO): [0] BUSY.
  - 0x2 GPO: [GPO_CNT-1:0] drive spi_gpo_o directly.
  - 0x3 GPI (RO): [GPI_CNT-1:0] spi_gpi_i.
  - 0x9 TXDATA: 32-bit shift source.
  - 0xA CLKDIV: [7:0] DIV. SCLK half-period is DIV+1 clk_r cycles.
- A CTRL write with START=1 while idle starts a transfer of LEN bits from TXDATA.
  - LEN=0: no transfer; the other CTRL fields are still stored.
  - LEN>32: clamped to 32.
- While BUSY, writes to CTRL, TXDATA and CLKDIV are acked but ignored. GPO writes always take effect.
- Bit order:
  - MSBF=1: bits LEN-1 down to 0 are sent.
  - MSBF=0: bits 0 up to LEN-1 are sent.
- CSIDX<CS_CNT: spi_cs_o[CSIDX] is driven low during the transfer. CSIDX>=CS_CNT: no CS is asserted, but the clocking still runs.
- CSHOLD=1: the CS stays low after completion until the next transfer ends with CSHOLD=0, or until a CTRL write with START=0 and CSHOLD=0 releases it.
- Reset values:
  - spi_clk_o=0, spi_dat_o=0, spi_cs_o all 1, spi_gpo_o=0.
  - up_wack=0, up_rack=0, up_rdata=0.
  - All registers 0, BUSY=0.
- An asserted rst_r during a transfer aborts it immediately and forces all reset values.

## Timing
- up_wack is a one-cycle pulse in the cycle after up_wreq. up_rack with valid up_rdata is a one-cycle pulse in the cycle after up_rreq. Reads and writes in the same cycle are both served.
- START accepted at edge T:
  - From T+1: BUSY=1, the CS goes low, and spi_dat_o presents the first bit.
  - spi_clk_o rises DIV+1 cycles after the data change and falls DIV+1 cycles later.
  - The next bit is presented on each falling edge.
- After the last falling edge there is one more half-period, then CS deasserts (unless CSHOLD), BUSY clears, and spi_dat_o returns to 0.
- Total BUSY duration is (2·LEN+1)·(DIV+1) cycles. Example: LEN=8, DIV=1 gives 34 cycles.

## Configuration
- UP_LCD_GPI_SYNC_EN defined: spi_gpi_i passes through a 2-flop synchronizer, so a GPI read reflects the input 2 cycles late.
- UP_LCD_GPI_SYNC_EN undefined: GPI is sampled directly into up_rdata.

## Structure
- Package up_lcd_pkg holds:
  - the register address constants;
  - the CTRL bit positions (START, LEN, CSIDX, MSBF, CSHOLD);
  - the shift-engine state typedef (IDLE, SHIFT_LO, SHIFT_HI, TAIL).
- Sub-module up_lcd_spi_shift contains the divider, the bit counter and the shift register. The top level holds the register file and the bus handshake.

## Test plan
- CLKDIV=1, TXDATA(0x9)=0x34, CTRL=0x10809 (LEN=8, MSBF=1, CSIDX=0): spi_cs_o[0] low for 34 cycles. Eight SCLK rises sample 0,0,1,1,0,1,0,0. BUSY then clears.
- CTRL=0x10802 (CSIDX=0, MSBF=0, LEN=8): the bits of the held TXDATA 0x34 are sent LSB first (0,0,1,0,1,1,0,0).
- CTRL write with START during BUSY: acked, no second transfer, waveform unchanged.
- GPO write 0x1 mid-transfer: spi_gpo_o[0]=1 on the next cycle, transfer undisturbed. GPI read returns spi_gpi_i.
- CTRL=0x10C14 (CSHOLD, CSIDX=1): cs[1] stays low after BUSY clears. CTRL=0x0 releases it.
- rst_r pulse mid-transfer: all outputs return to reset values immediately. A read of 0xA returns 0.
